// File: rtl/chain_dp_scheduler.sv
// Handshaked sequencer for the matrix-chain DP datapath: diagonal zero-init writes,
// then per-cell (i,j,k) split-point steps, a wait for the cell minimum, and the cell write.
module chain_dp_scheduler #(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] matlen,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] ir,
  output logic [IDX_W-1:0] jr,
  output logic [IDX_W-1:0] kr,
  output logic             step_valid,
  input  logic             step_ready,
  output logic             step_first,
  output logic             step_last,
  input  logic             cell_done,
  output logic             rw,
  output logic             wr_init,
  output logic [IDX_W-1:0] iw,
  output logic [IDX_W-1:0] jw
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [IDX_W-1:0] ZERO = '0;
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] TWO  = IDX_W'(2);

  logic [2:0]       r_state, w_state;
  logic [IDX_W-1:0] r_n, r_L, r_i, r_k;
  logic [IDX_W-1:0] w_n, w_L, w_i, w_k;
  logic [IDX_W-1:0] r_ir, r_jr, r_kr, r_iw, r_jw;
  logic [IDX_W-1:0] w_j;
  logic             w_step_last;

  assign w_j         = r_i + r_L - ONE;
  assign w_step_last = (r_k == r_i + r_L - TWO);

  always_comb begin
    w_state = r_state;
    w_n     = r_n;
    w_L     = r_L;
    w_i     = r_i;
    w_k     = r_k;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_n = matlen;
          w_i = ZERO;
          w_state = (matlen == ZERO) ? S_DONE : S_INIT;
        end
      end
      S_INIT: begin
        if (r_i == r_n - ONE) begin
          if (r_n == ONE) begin
            w_state = S_DONE;
          end else begin
            w_L     = TWO;
            w_i     = ZERO;
            w_k     = ZERO;
            w_state = S_STEP;
          end
        end else begin
          w_i = r_i + ONE;
        end
      end
      S_STEP: begin
        if (step_ready) begin
          if (w_step_last) w_state = S_WAIT;
          else             w_k = r_k + ONE;
        end
      end
      S_WAIT: begin
        if (cell_done) w_state = S_WRITE;
      end
      S_WRITE: begin
        // Next cell on this diagonal, else first cell of the next longer chain.
        if (r_i < r_n - r_L) begin
          w_i     = r_i + ONE;
          w_k     = r_i + ONE;
          w_state = S_STEP;
        end else if (r_L < r_n) begin
          w_L     = r_L + ONE;
          w_i     = ZERO;
          w_k     = ZERO;
          w_state = S_STEP;
        end else begin
          w_state = S_DONE;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n     <= ZERO;
      r_L     <= ZERO;
      r_i     <= ZERO;
      r_k     <= ZERO;
      r_ir    <= ZERO;
      r_jr    <= ZERO;
      r_kr    <= ZERO;
      r_iw    <= ZERO;
      r_jw    <= ZERO;
    end else begin
      r_state <= w_state;
      r_n     <= w_n;
      r_L     <= w_L;
      r_i     <= w_i;
      r_k     <= w_k;
      // Index outputs load only when entering a qualified state, so they hold otherwise.
      if (w_state == S_STEP) begin
        r_ir <= w_i;
        r_jr <= w_i + w_L - ONE;
        r_kr <= w_k;
      end
      if (w_state == S_INIT) begin
        r_iw <= w_i;
        r_jw <= w_i;
      end else if (w_state == S_WRITE) begin
        r_iw <= r_i;
        r_jw <= w_j;
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign step_valid = (r_state == S_STEP);
  assign step_first = step_valid && (r_kr == r_ir);
  assign step_last  = step_valid && (r_kr == r_jr - ONE);
  assign rw         = (r_state == S_INIT) || (r_state == S_WRITE);
  assign wr_init    = (r_state == S_INIT);
  assign ir         = r_ir;
  assign jr         = r_jr;
  assign kr         = r_kr;
  assign iw         = r_iw;
  assign jw         = r_jw;

endmodule

// File: tb/tb_chain_dp_scheduler.sv
// Directed bench for chain_dp_scheduler: cycle-exact n=3 schedule, n=0/1 corners,
// backpressure, cell_done timing, start-while-busy and asynchronous mid-schedule reset.
module tb_chain_dp_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] matlen = 8'd0;
  logic       step_ready = 1'b0;
  logic       cell_done = 1'b0;
  logic       busy, done, step_valid, step_first, step_last, rw, wr_init;
  logic [7:0] ir, jr, kr, iw, jw;

  chain_dp_scheduler #(.IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matlen(matlen),
    .busy(busy), .done(done), .ir(ir), .jr(jr), .kr(kr),
    .step_valid(step_valid), .step_ready(step_ready),
    .step_first(step_first), .step_last(step_last),
    .cell_done(cell_done), .rw(rw), .wr_init(wr_init), .iw(iw), .jw(jw)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int   cnt_rw, cnt_step, cnt_done, cnt_sv;
  logic [7:0] last_iw, last_jw;
  logic clr = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      cnt_rw = 0; cnt_step = 0; cnt_done = 0; cnt_sv = 0;
      last_iw = 8'd0; last_jw = 8'd0;
    end else if (rst_n) begin
      if (rw) begin
        cnt_rw = cnt_rw + 1;
        last_iw = iw;
        last_jw = jw;
      end
      if (step_valid) cnt_sv = cnt_sv + 1;
      if (step_valid && step_ready) cnt_step = cnt_step + 1;
      if (done) cnt_done = cnt_done + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] obs();
    return 64'({busy, done, rw, wr_init, step_valid, step_first, step_last,
                rw ? iw : 8'd0, rw ? jw : 8'd0,
                step_valid ? ir : 8'd0, step_valid ? jr : 8'd0, step_valid ? kr : 8'd0});
  endfunction

  function automatic logic [63:0] raw_all();
    return 64'({busy, done, step_valid, step_first, step_last, rw, wr_init, ir, jr, kr, iw, jw});
  endfunction

  // kind: 0 wait, 1 init write, 2 cell write, 3 step first, 4 step last,
  // 5 step first&last, 6 step middle, 7 done
  function automatic logic [63:0] expv(input int kind, input int a, input int b, input int c);
    logic [6:0]  f;
    logic [15:0] w;
    logic [23:0] s;
    w = 16'd0;
    s = 24'd0;
    case (kind)
      1: f = 7'b1011000;
      2: f = 7'b1010000;
      3: f = 7'b1000110;
      4: f = 7'b1000101;
      5: f = 7'b1000111;
      6: f = 7'b1000100;
      7: f = 7'b1100000;
      default: f = 7'b1000000;
    endcase
    if (kind == 1 || kind == 2) w = {a[7:0], b[7:0]};
    if (kind >= 3 && kind <= 6) s = {a[7:0], b[7:0], c[7:0]};
    return 64'({f, w, s});
  endfunction

  task automatic run_n3(input bit disturb);
    int ka[14] = '{1, 1, 1, 5, 0, 2, 5, 0, 2, 3, 4, 0, 2, 7};
    int aa[14] = '{0, 1, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    int bb[14] = '{0, 1, 2, 1, 0, 1, 2, 0, 2, 2, 2, 0, 2, 0};
    int cc[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    string pfx;
    pfx = disturb ? "n3dist" : "n3";
    clear_counts();
    step_ready = 1'b1;
    cell_done  = 1'b1;
    matlen     = 8'd3;
    start      = 1'b1;
    tick();
    for (int t = 0; t < 14; t++) begin
      check_eq($sformatf("%s_cyc%0d", pfx, t + 1), obs(), expv(ka[t], aa[t], bb[t], cc[t]));
      if (disturb && (t == 4 || t == 9 || t == 12)) begin
        start  = 1'b1;
        matlen = 8'd2;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_eq({pfx, "_idle_after"}, 64'(busy), 64'd0);
    tick();
    tick();
    check_eq({pfx, "_done_cnt"}, 64'(cnt_done), 64'd1);
    check_eq({pfx, "_rw_cnt"}, 64'(cnt_rw), 64'd6);
    check_eq({pfx, "_step_cnt"}, 64'(cnt_step), 64'd4);
  endtask

  initial begin
    int  cyc;
    bit  stalled;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outputs", raw_all(), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("reset_idle", raw_all(), 64'd0);

    // Undisturbed n=3 schedule
    run_n3(1'b0);

    // n=0
    clear_counts();
    matlen = 8'd0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check_eq("n0_done", obs(), expv(7, 0, 0, 0));
    tick();
    check_eq("n0_idle", 64'(busy), 64'd0);
    tick();
    check_eq("n0_no_rw", 64'(cnt_rw), 64'd0);
    check_eq("n0_no_sv", 64'(cnt_sv), 64'd0);

    // n=1
    clear_counts();
    matlen = 8'd1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check_eq("n1_init", obs(), expv(1, 0, 0, 0));
    tick();
    check_eq("n1_done", obs(), expv(7, 0, 0, 0));
    tick();
    check_eq("n1_idle", 64'(busy), 64'd0);
    tick();
    check_eq("n1_rw_cnt", 64'(cnt_rw), 64'd1);

    // Backpressure on step (0,3,1), n=4
    clear_counts();
    step_ready = 1'b1;
    cell_done  = 1'b1;
    matlen     = 8'd4;
    start      = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 0;
    stalled = 1'b0;
    while (!done && cyc < 300) begin
      if (!stalled && step_valid && ir == 8'd0 && jr == 8'd3 && kr == 8'd1) begin
        stalled    = 1'b1;
        step_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_eq($sformatf("bp_hold%0d", s), 64'({step_valid, ir, jr, kr}),
                   64'({1'b1, 8'd0, 8'd3, 8'd1}));
        end
        step_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    check_eq("bp_done_seen", 64'(done), 64'd1);
    check_eq("bp_stall_seen", 64'(stalled), 64'd1);
    tick();
    tick();
    check_eq("bp_step_cnt", 64'(cnt_step), 64'd10);
    check_eq("bp_rw_cnt", 64'(cnt_rw), 64'd10);
    check_eq("bp_last_write", 64'({last_iw, last_jw}), 64'({8'd0, 8'd3}));
    check_eq("bp_done_cnt", 64'(cnt_done), 64'd1);

    // cell_done early/held, then delayed 5 cycles in WAIT, n=2
    clear_counts();
    step_ready = 1'b1;
    cell_done  = 1'b0;
    matlen     = 8'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    check_eq("cd_init0", obs(), expv(1, 0, 0, 0));
    cell_done = 1'b1;
    tick();
    check_eq("cd_init1", obs(), expv(1, 1, 1, 0));
    cell_done = 1'b0;
    tick();
    check_eq("cd_step", obs(), expv(5, 0, 1, 0));
    cell_done = 1'b1;
    tick();
    cell_done = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check_eq($sformatf("cd_wait%0d", s), obs(), expv(0, 0, 0, 0));
      tick();
    end
    cell_done = 1'b1;
    tick();
    cell_done = 1'b0;
    check_eq("cd_write", obs(), expv(2, 0, 1, 0));
    tick();
    check_eq("cd_done", obs(), expv(7, 0, 0, 0));
    tick();

    // start pulsed while busy
    run_n3(1'b1);

    // Asynchronous reset while a step is offered, n=4
    clear_counts();
    step_ready = 1'b0;
    cell_done  = 1'b0;
    matlen     = 8'd4;
    start      = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 0;
    while (!step_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("rst_sv_before", 64'(step_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_outputs", raw_all(), 64'd0);
    clear_counts();
    step_ready = 1'b1;
    cell_done  = 1'b1;
    tick();
    #2 rst_n = 1'b1;
    repeat (6) tick();
    check_eq("rst_stays_idle", raw_all(), 64'd0);
    check_eq("rst_no_done", 64'(cnt_done), 64'd0);
    check_eq("rst_no_rw", 64'(cnt_rw), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
